reg_writeback: RTL
==================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-003 The block SHALL have the port alu_valid, input, 1 bit: ALU result write request; always accepted, no back-pressure.
REQ-004 The block SHALL have the port alu_rd, input, 5 bits: destination register of the ALU result.
REQ-005 The block SHALL have the port alu_data, input, 32 bits: ALU result data.
REQ-006 The block SHALL have the port ld_valid, input, 1 bit: load-unit write request.
REQ-007 The block SHALL have the ports ld_rd (input, 5 bits) and ld_data (input, 32 bits): load destination register and load data.
REQ-008 The block SHALL have the port ld_ready, output, 1 bit: a load is accepted in a cycle with ld_valid && ld_ready.
REQ-009 The block SHALL have the port issue_valid, input, 1 bit: an instruction writing issue_rd has issued.
REQ-010 The block SHALL have the port issue_rd, input, 5 bits: destination register of the issued instruction.
REQ-011 The block SHALL have the ports chk_rs1 and chk_rs2, inputs, 5 bits each: source registers to hazard-check.
REQ-012 The block SHALL have the port stall, output, 1 bit: a checked source register has a pending write.
REQ-013 The block SHALL have the ports A3 (output, 5 bits), WE3 (output, 1 bit) and WD3 (output, 32 bits): register-file write port, which the register file commits on the CLK falling edge.

Function
REQ-014 Outputs A3, WE3 and WD3 SHALL be registered, with one-cycle latency from an accepted request to WE3=1.
REQ-015 At most one write SHALL be emitted per cycle.
REQ-016 A load SHALL be accepted only when ld_valid && ld_ready.
REQ-017 An accepted load SHALL be enqueued in a 2-entry in-order FIFO.
REQ-018 ld_ready SHALL equal (FIFO count < 2), combinational from state only; it is not asserted on same-cycle dequeue when full.
REQ-019 Arbitration: when alu_valid=1 with alu_rd!=0, the ALU write SHALL be emitted at the next edge and the FIFO SHALL NOT dequeue that cycle.
REQ-020 Arbitration: otherwise, when the FIFO is non-empty, the FIFO head SHALL be emitted and dequeued.
REQ-021 Arbitration: otherwise, WE3 SHALL be 0 at the next edge.
REQ-022 When WE3=0, A3 and WD3 SHALL hold their previous values.
REQ-023 Writes to x0: an ALU request with alu_rd=0 SHALL be discarded and SHALL NOT block the FIFO.
REQ-024 Writes to x0: a load with ld_rd=0 SHALL be accepted (when ld_ready=1) and dropped without enqueue.
REQ-025 Writes to x0: WE3 SHALL never be 1 with A3=0.
REQ-026 Same-cycle enqueue and dequeue with the FIFO at count 1 SHALL leave count at 1 and preserve order.
REQ-027 The block SHALL hold a 32-bit pending scoreboard; bit 0 is hardwired 0.
REQ-028 Scoreboard set: issue_valid with issue_rd!=0 SHALL set pending[issue_rd] at the edge.
REQ-029 Scoreboard clear: emitting a write to register r SHALL clear pending[r] at the same edge that WE3 rises.
REQ-030 When set and clear target the same register in one cycle, set SHALL win.
REQ-031 stall SHALL equal pending[chk_rs1] | pending[chk_rs2], combinational.
REQ-032 stall SHALL fall in the cycle after the emitting edge; a read in that cycle sees the new value after the falling-edge commit.
REQ-033 The FIFO SHALL NOT overflow; ld_valid while ld_ready=0 is not accepted, and the producer holds ld_rd and ld_data.
REQ-034 The FIFO count SHALL never exceed 2 or go below 0, under all input sequences.

Reset
REQ-035 While reset_n=0 at a rising edge, WE3, A3, WD3 and pending SHALL all become 0 and the FIFO SHALL become empty.
REQ-036 ld_ready SHALL be forced to 0 while reset_n=0.
REQ-037 Reset SHALL override all same-cycle requests: issue, ALU and load requests are ignored and queued loads are lost.
REQ-038 After reset_n returns to 1, ld_ready SHALL be 1 and stall SHALL be 0.
REQ-039 Assertion of reset_n=0 mid-drain SHALL emit no further writes from the flushed FIFO.

Verification
REQ-040 ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; then WE3=0.
REQ-041 Priority: FIFO holds (7, 0x11); alu_valid on rd=3 for 2 cycles -> writes emitted as rd3, rd3, then rd7=0x11.
REQ-042 Back-pressure: 3 consecutive loads (rd 8, 9, 10) while alu_valid=1 -> ld_ready=0 after 2 accepts.
REQ-043 Back-pressure drain: once alu_valid drops, writes 8, 9, 10 are emitted in order with no loss.
REQ-044 Scoreboard: issue rd=12; chk_rs1=12 -> stall=1 until the load to 12 is emitted, stall=0 the following cycle.
REQ-045 Scoreboard set-wins: issue rd=12 in the same cycle as emission to 12 -> pending[12] stays 1.
REQ-046 x0 and reset: alu_rd=0 -> WE3 stays 0.
REQ-047 Reset mid-drain: reset_n=0 with FIFO count 2 -> no further WE3 pulses, pending=0, ld_ready=1 after release.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Register-writeback bus: ALU and load write requests, issue/hazard-check
// signals and the register-file write port.
interface reg_writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        stall;
    logic [4:0]  A3;
    logic        WE3;
    logic [31:0] WD3;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd, chk_rs1, chk_rs2,
        input  ld_ready, stall, A3, WE3, WD3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2,
        output ld_ready, stall, A3, WE3, WD3
    );
endinterface

// File: rtl/reg_writeback.sv
// Writeback arbiter: ALU results take priority over a 2-entry in-order load
// FIFO; one registered write per cycle to the register file. A pending-write
// scoreboard drives the hazard stall.
module reg_writeback (
    input logic           CLK,
    input logic           reset_n,
    reg_writeback_if.slave bus
);
    logic [4:0]  fifo_rd   [2];
    logic [31:0] fifo_data [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [31:0] pending;

    logic        we3_q;
    logic [4:0]  a3_q;
    logic [31:0] wd3_q;

    logic        ld_ready;
    logic        ld_acc;
    logic        enq;
    logic        alu_go;
    logic        deq;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] pending_next;

    // Handshake, arbitration and scoreboard masks for this cycle.
    always_comb begin
        ld_ready = reset_n && (count != 2'd2);
        ld_acc   = bus.ld_valid && ld_ready;
        // Loads to x0 are accepted but never occupy a FIFO slot.
        enq      = ld_acc && (bus.ld_rd != 5'd0);
        // ALU writes to x0 are dropped and do not hold off the FIFO.
        alu_go   = bus.alu_valid && (bus.alu_rd != 5'd0);
        deq      = !alu_go && (count != 2'd0);

        clr_mask = 32'd0;
        if (alu_go)
            clr_mask = 32'd1 << bus.alu_rd;
        else if (deq)
            clr_mask = 32'd1 << fifo_rd[rd_ptr];

        set_mask = 32'd0;
        if (bus.issue_valid)
            set_mask = 32'd1 << bus.issue_rd;

        // Set is applied after clear so a same-cycle reissue keeps the bit.
        pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end

    // FIFO pointers and occupancy; reset discards any queued loads.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge CLK) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= bus.ld_rd;
            fifo_data[wr_ptr] <= bus.ld_data;
        end
    end

    // Registered write port; address and data hold when no write is emitted.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            we3_q <= 1'b0;
            a3_q  <= 5'd0;
            wd3_q <= 32'd0;
        end else if (alu_go) begin
            we3_q <= 1'b1;
            a3_q  <= bus.alu_rd;
            wd3_q <= bus.alu_data;
        end else if (deq) begin
            we3_q <= 1'b1;
            a3_q  <= fifo_rd[rd_ptr];
            wd3_q <= fifo_data[rd_ptr];
        end else begin
            we3_q <= 1'b0;
        end
    end

    // Pending-write scoreboard, cleared on the edge the write is emitted.
    always_ff @(posedge CLK) begin
        if (!reset_n) pending <= 32'd0;
        else          pending <= pending_next;
    end

    // Drive the interface outputs.
    always_comb begin
        bus.ld_ready = ld_ready;
        bus.stall    = pending[bus.chk_rs1] | pending[bus.chk_rs2];
        bus.WE3      = we3_q;
        bus.A3       = a3_q;
        bus.WD3      = wd3_q;
    end
endmodule
